// File: rtl/sprite_gpu_pkg.sv
// Shared sprite GPU definitions: bus widths, default colour key and the
// pixel-fetch state encoding.
package sprite_gpu_pkg;

    localparam int unsigned ADDR_W      = 23;
    localparam int unsigned COORD_W     = 11;
    localparam int unsigned DEF_COLOR_W = 16;

    localparam logic [DEF_COLOR_W-1:0] DEF_TRANSPARENT = 16'hF81F;

    localparam logic [2:0] FS_IDLE  = 3'd0;
    localparam logic [2:0] FS_REQ   = 3'd1;
    localparam logic [2:0] FS_WAIT  = 3'd2;
    localparam logic [2:0] FS_CHECK = 3'd3;
    localparam logic [2:0] FS_EMIT  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = FS_IDLE,
        ST_REQ   = FS_REQ,
        ST_WAIT  = FS_WAIT,
        ST_CHECK = FS_CHECK,
        ST_EMIT  = FS_EMIT
    } fetch_state_t;

    // Index width for a vector of n entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_priority_enc.sv
// Combinational lowest-set-bit encoder: index of the lowest set bit of
// i_vec plus an any-bit-set flag.
module sprite_priority_enc
    import sprite_gpu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    localparam int unsigned IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx_c,
    output logic             o_any_c
);

    // Scan downwards so the lowest set bit is the one that sticks.
    always_comb begin
        o_idx_c = '0;
        o_any_c = |i_vec;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx_c = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sprite_pixel_fetch.sv
// Per-pixel sprite colour fetch: picks the lowest-index live sprite, reads its
// colour, applies the transparency key. Build option: SPRITE_FALLTHROUGH_EN.
module sprite_pixel_fetch
    import sprite_gpu_pkg::*;
#(
    parameter int unsigned        NUM_SPRITES = 8,
    parameter int unsigned        COLOR_W     = DEF_COLOR_W,
    parameter logic [COLOR_W-1:0] TRANSPARENT = COLOR_W'(DEF_TRANSPARENT)
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          PixelValid,
    output logic                          Ready,
    input  logic signed [COORD_W-1:0]     CurrentX,
    input  logic signed [COORD_W-1:0]     CurrentY,
    input  logic [COLOR_W-1:0]            BgColour,
    input  logic [NUM_SPRITES-1:0]        SpriteInRange,
    input  logic [ADDR_W*NUM_SPRITES-1:0] SpriteAddr,
    output logic                          MemReq,
    output logic [ADDR_W-1:0]             MemAddr,
    input  logic                          MemAck,
    input  logic                          MemDataValid,
    input  logic [COLOR_W-1:0]            MemData,
    output logic [COLOR_W-1:0]            PixelOut,
    output logic                          PixelOutValid,
    output logic                          PixelIsSprite,
    output logic signed [COORD_W-1:0]     OutX,
    output logic signed [COORD_W-1:0]     OutY,
    output logic                          Overrun
);

    localparam int unsigned IDX_W = idx_width(NUM_SPRITES);

    fetch_state_t               r_state;
    logic                       r_ready;
    logic                       r_mem_req;
    logic [ADDR_W-1:0]          r_mem_addr;
    logic [COLOR_W-1:0]         r_pix_out;
    logic                       r_out_valid;
    logic                       r_out_sprite;
    logic signed [COORD_W-1:0]  r_out_x;
    logic signed [COORD_W-1:0]  r_out_y;
    logic                       r_overrun;

    logic signed [COORD_W-1:0]  r_x;
    logic signed [COORD_W-1:0]  r_y;
    logic [COLOR_W-1:0]         r_bg;
    logic [NUM_SPRITES-1:0]     r_mask;
    logic [ADDR_W-1:0]          r_addr [NUM_SPRITES];
    logic [IDX_W-1:0]           r_idx;
    logic [COLOR_W-1:0]         r_data;
    logic [COLOR_W-1:0]         r_colour;
    logic                       r_is_sprite;

    logic [ADDR_W-1:0]          w_addr_in [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]     w_cand;
    logic [NUM_SPRITES-1:0]     w_mask_rest;
    logic [NUM_SPRITES-1:0]     w_enc_in;
    logic [IDX_W-1:0]           w_sel_idx;
    logic                       w_sel_any;

    // A sprite with a null address can never supply a pixel.
    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_cand
        assign w_addr_in[g] = SpriteAddr[ADDR_W*g +: ADDR_W];
        assign w_cand[g]    = SpriteInRange[g] && (w_addr_in[g] != '0);
    end

    assign w_mask_rest = r_mask & ~(NUM_SPRITES'(1) << r_idx);
    assign w_enc_in    = (r_state == ST_IDLE) ? w_cand : w_mask_rest;

    sprite_priority_enc #(
        .WIDTH (NUM_SPRITES)
    ) u_prio (
        .i_vec   (w_enc_in),
        .o_idx_c (w_sel_idx),
        .o_any_c (w_sel_any)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= ST_IDLE;
            r_ready      <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_pix_out    <= '0;
            r_out_valid  <= 1'b0;
            r_out_sprite <= 1'b0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_overrun    <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_bg         <= '0;
            r_mask       <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_addr[i] <= '0;
            end
            r_idx        <= '0;
            r_data       <= '0;
            r_colour     <= '0;
            r_is_sprite  <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (PixelValid && !r_ready) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (PixelValid) begin
                        r_x     <= CurrentX;
                        r_y     <= CurrentY;
                        r_bg    <= BgColour;
                        r_mask  <= w_cand;
                        r_addr  <= w_addr_in;
                        r_ready <= 1'b0;
                        if (w_sel_any) begin
                            r_idx      <= w_sel_idx;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= w_addr_in[w_sel_idx];
                            r_state    <= ST_REQ;
                        end else begin
                            r_colour    <= BgColour;
                            r_is_sprite <= 1'b0;
                            r_state     <= ST_EMIT;
                        end
                    end
                end
                ST_REQ: begin
                    if (MemAck) begin
                        r_mem_req <= 1'b0;
                        if (MemDataValid) begin
                            r_data  <= MemData;
                            r_state <= ST_CHECK;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (MemDataValid) begin
                        r_data  <= MemData;
                        r_state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (r_data != TRANSPARENT) begin
                        r_colour    <= r_data;
                        r_is_sprite <= 1'b1;
                        r_state     <= ST_EMIT;
                    end else begin
`ifdef SPRITE_FALLTHROUGH_EN
                        // Transparent: retire this sprite and try the next live one.
                        r_mask <= w_mask_rest;
                        if (w_sel_any) begin
                            r_idx      <= w_sel_idx;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_addr[w_sel_idx];
                            r_state    <= ST_REQ;
                        end else begin
                            r_colour    <= r_bg;
                            r_is_sprite <= 1'b0;
                            r_state     <= ST_EMIT;
                        end
`else
                        r_colour    <= r_bg;
                        r_is_sprite <= 1'b0;
                        r_state     <= ST_EMIT;
`endif
                    end
                end
                ST_EMIT: begin
                    r_out_valid  <= 1'b1;
                    r_pix_out    <= r_colour;
                    r_out_sprite <= r_is_sprite;
                    r_out_x      <= r_x;
                    r_out_y      <= r_y;
                    r_ready      <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_ready   <= 1'b1;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign Ready         = r_ready;
    assign MemReq        = r_mem_req;
    assign MemAddr       = r_mem_addr;
    assign PixelOut      = r_pix_out;
    assign PixelOutValid = r_out_valid;
    assign PixelIsSprite = r_out_sprite;
    assign OutX          = r_out_x;
    assign OutY          = r_out_y;
    assign Overrun       = r_overrun;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Self-checking bench for sprite_pixel_fetch: directed scenarios plus random
// pixels against a behavioural priority/transparency model.
module tb_sprite_pixel_fetch;

    localparam int unsigned N  = 8;
    localparam logic [15:0] TR = 16'hF81F;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic               PixelValid = 1'b0;
    logic               Ready;
    logic signed [10:0] CurrentX = '0;
    logic signed [10:0] CurrentY = '0;
    logic [15:0]        BgColour = '0;
    logic [N-1:0]       SpriteInRange = '0;
    logic [23*N-1:0]    SpriteAddr = '0;
    logic               MemReq;
    logic [22:0]        MemAddr;
    logic               MemAck = 1'b0;
    logic               MemDataValid = 1'b0;
    logic [15:0]        MemData = '0;
    logic [15:0]        PixelOut;
    logic               PixelOutValid;
    logic               PixelIsSprite;
    logic signed [10:0] OutX;
    logic signed [10:0] OutY;
    logic               Overrun;

    int          errors = 0;
    int          checks = 0;
    int          ack_dly = 0;
    int          dv_dly = 0;
    bit          manual = 1'b0;
    logic [22:0] req_q[$];
    logic [22:0] exp_q[$];

    sprite_pixel_fetch dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .PixelValid    (PixelValid),
        .Ready         (Ready),
        .CurrentX      (CurrentX),
        .CurrentY      (CurrentY),
        .BgColour      (BgColour),
        .SpriteInRange (SpriteInRange),
        .SpriteAddr    (SpriteAddr),
        .MemReq        (MemReq),
        .MemAddr       (MemAddr),
        .MemAck        (MemAck),
        .MemDataValid  (MemDataValid),
        .MemData       (MemData),
        .PixelOut      (PixelOut),
        .PixelOutValid (PixelOutValid),
        .PixelIsSprite (PixelIsSprite),
        .OutX          (OutX),
        .OutY          (OutY),
        .Overrun       (Overrun)
    );

    always #5 Clk = ~Clk;

    // Sprite memory contents.
    function automatic logic [15:0] mem_fn(input logic [22:0] a);
        if (a == 23'h100) return 16'h07E0;
        if (a[3:0] == 4'hF) return TR;
        return a[15:0] ^ 16'hA5C3;
    endfunction

    // Memory responder: ack after ack_dly request cycles, data dv_dly cycles later.
    initial begin : responder
        int          cnt;
        bit          busy;
        logic [15:0] d;
        cnt = 0; busy = 0; d = '0;
        forever begin
            @(posedge Clk); #1;
            if (manual) begin
                cnt = 0; busy = 0;
                continue;
            end
            MemAck = 1'b0; MemDataValid = 1'b0; MemData = 16'($urandom);
            if (Reset) begin
                cnt = 0; busy = 0;
                continue;
            end
            if (!busy) begin
                if (MemReq) begin
                    if (cnt >= ack_dly) begin
                        MemAck = 1'b1;
                        req_q.push_back(MemAddr);
                        d = mem_fn(MemAddr);
                        cnt = 0;
                        if (dv_dly == 0) begin
                            MemDataValid = 1'b1; MemData = d;
                        end else begin
                            busy = 1;
                        end
                    end else begin
                        cnt++;
                    end
                end
            end else begin
                cnt++;
                if (cnt >= dv_dly) begin
                    MemDataValid = 1'b1; MemData = d; busy = 0; cnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Reference: lowest-index candidate with a non-null address wins; a
    // transparent word either falls through to the next candidate or gives bg.
    task automatic model(input logic [N-1:0] inr, input logic [22:0] a[N], input logic [15:0] bg,
                         output logic [15:0] col, output bit spr);
        int cands[$];
        for (int i = 0; i < N; i++) if (inr[i] && a[i] != 23'd0) cands.push_back(i);
        col = bg; spr = 0;
        exp_q.delete();
        for (int k = 0; k < cands.size(); k++) begin
            exp_q.push_back(a[cands[k]]);
            if (mem_fn(a[cands[k]]) != TR) begin
                col = mem_fn(a[cands[k]]); spr = 1;
                break;
            end
`ifndef SPRITE_FALLTHROUGH_EN
            break;
`endif
        end
    endtask

    task automatic drive_addrs(input logic [22:0] a[N]);
        for (int i = 0; i < N; i++) SpriteAddr[23*i +: 23] = a[i];
    endtask

    task automatic clear_addrs(output logic [22:0] a[N]);
        for (int i = 0; i < N; i++) a[i] = 23'd0;
    endtask

    task automatic run_pixel(input string nm, input logic signed [10:0] x, input logic signed [10:0] y,
                             input logic [15:0] bg, input logic [N-1:0] inr, input logic [22:0] a[N],
                             output logic [15:0] got_col, output bit got_spr);
        logic [15:0] ecol;
        bit          espr;
        bit          seen;
        bit          rd_ok;
        int          cyc;
        int          w;
        int          elat;
        logic [22:0] junk[N];
        w = 0;
        while (!Ready && w < 50) begin
            @(posedge Clk); #1; w++;
        end
        checks++;
        if (Ready !== 1'b1) begin
            errors++; $display("FAIL %s ready_wait: Ready=%b required 1", nm, Ready);
        end
        model(inr, a, bg, ecol, espr);
        elat = (exp_q.size() == 0) ? 2 : 2 + exp_q.size() * (2 + ack_dly + dv_dly);
        req_q.delete();
        CurrentX = x; CurrentY = y; BgColour = bg; SpriteInRange = inr;
        drive_addrs(a);
        PixelValid = 1'b1;
        cyc = 0; seen = 0;
        while (cyc < 200) begin
            @(posedge Clk); #1; cyc++;
            if (cyc == 1) begin
                PixelValid = 1'b0;
                for (int i = 0; i < N; i++) junk[i] = 23'($urandom);
                drive_addrs(junk);
                SpriteInRange = N'($urandom); CurrentX = 11'($urandom);
                CurrentY = 11'($urandom); BgColour = 16'($urandom);
                checks++;
                if (Ready !== 1'b0) begin
                    errors++; $display("FAIL %s busy_ready: Ready=%b required 0", nm, Ready);
                end
            end
            if (PixelOutValid === 1'b1) begin
                seen = 1; break;
            end
        end
        got_col = PixelOut; got_spr = PixelIsSprite;
        checks++;
        if (!seen) begin
            errors++; $display("FAIL %s timeout: no PixelOutValid within %0d cycles", nm, cyc);
        end else begin
            if (PixelOut !== ecol) begin
                errors++; $display("FAIL %s colour: got %h required %h", nm, PixelOut, ecol);
            end
            checks++;
            if (PixelIsSprite !== espr) begin
                errors++; $display("FAIL %s is_sprite: got %b required %b", nm, PixelIsSprite, espr);
            end
            checks++;
            if (OutX !== x || OutY !== y) begin
                errors++; $display("FAIL %s coords: got (%0d,%0d) required (%0d,%0d)", nm, OutX, OutY, x, y);
            end
            checks++;
            if (cyc != elat) begin
                errors++; $display("FAIL %s latency: got %0d required %0d", nm, cyc, elat);
            end
            checks++;
            rd_ok = (req_q.size() == exp_q.size());
            if (rd_ok) for (int k = 0; k < exp_q.size(); k++) if (req_q[k] !== exp_q[k]) rd_ok = 0;
            if (!rd_ok) begin
                errors++; $display("FAIL %s reads: got %0d reads required %0d", nm, req_q.size(), exp_q.size());
            end
            @(posedge Clk); #1;
            checks++;
            if (PixelOutValid !== 1'b0) begin
                errors++; $display("FAIL %s strobe_width: PixelOutValid=%b required 0", nm, PixelOutValid);
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (Ready !== 1'b1 || MemReq !== 1'b0 || PixelOutValid !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: Ready=%b MemReq=%b PixelOutValid=%b required 1 0 0", Ready, MemReq, PixelOutValid);
        end
        checks++;
        if (PixelIsSprite !== 1'b0 || Overrun !== 1'b0) begin
            errors++; $display("FAIL reset_flags: IsSprite=%b Overrun=%b required 0 0", PixelIsSprite, Overrun);
        end
        checks++;
        if (PixelOut !== 16'h0 || MemAddr !== 23'h0 || OutX !== 11'sd0 || OutY !== 11'sd0) begin
            errors++; $display("FAIL reset_data: PixelOut=%h MemAddr=%h OutX=%0d OutY=%0d required zeros", PixelOut, MemAddr, OutX, OutY);
        end
        Reset = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_no_sprite();
        logic [22:0] a[N];
        logic [15:0] c;
        bit          s;
        clear_addrs(a);
        ack_dly = 0; dv_dly = 0;
        run_pixel("no_sprite", 11'sd5, 11'sd7, 16'h001F, 8'h00, a, c, s);
        checks++;
        if (c !== 16'h001F || s !== 1'b0) begin
            errors++; $display("FAIL no_sprite_const: got %h/%b required 001f/0", c, s);
        end
    endtask

    task automatic test_sprite_hit();
        logic [22:0] a[N];
        logic [15:0] c;
        bit          s;
        clear_addrs(a);
        a[2] = 23'h100; a[5] = 23'h300;
        ack_dly = 0; dv_dly = 0;
        run_pixel("sprite_hit", -11'sd3, 11'sd100, 16'h1111, 8'b0010_0100, a, c, s);
        checks++;
        if (c !== 16'h07E0 || s !== 1'b1 || req_q.size() != 1 || req_q[0] !== 23'h100) begin
            errors++; $display("FAIL sprite_hit_const: got %h/%b reads=%0d required 07e0/1 one read at 100", c, s, req_q.size());
        end
    endtask

    task automatic test_zero_addr();
        logic [22:0] a[N];
        logic [15:0] c;
        bit          s;
        clear_addrs(a);
        run_pixel("zero_addr", 11'sd9, 11'sd1, 16'h2222, 8'b0000_1000, a, c, s);
        checks++;
        if (c !== 16'h2222 || s !== 1'b0 || req_q.size() != 0) begin
            errors++; $display("FAIL zero_addr_const: got %h/%b reads=%0d required 2222/0 no reads", c, s, req_q.size());
        end
    endtask

    task automatic test_transparent();
        logic [22:0] a[N];
        logic [15:0] c;
        bit          s;
        clear_addrs(a);
        a[1] = 23'h00F; a[4] = 23'h200;
        ack_dly = 1; dv_dly = 1;
        run_pixel("transparent", 11'sd20, 11'sd30, 16'h3333, 8'b0001_0010, a, c, s);
        checks++;
`ifdef SPRITE_FALLTHROUGH_EN
        if (c !== 16'hA7C3 || s !== 1'b1 || req_q.size() != 2) begin
            errors++; $display("FAIL transparent_const: got %h/%b reads=%0d required a7c3/1 two reads", c, s, req_q.size());
        end
`else
        if (c !== 16'h3333 || s !== 1'b0 || req_q.size() != 1) begin
            errors++; $display("FAIL transparent_const: got %h/%b reads=%0d required 3333/0 one read", c, s, req_q.size());
        end
`endif
    endtask

    task automatic test_random();
        logic [22:0] a[N];
        logic [15:0] c;
        bit          s;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       a[i] = 23'd0;
                    1:       a[i] = {19'($urandom), 4'hF};
                    default: a[i] = 23'($urandom);
                endcase
            end
            ack_dly = $urandom_range(0, 3);
            dv_dly  = $urandom_range(0, 3);
            run_pixel("random", 11'($urandom), 11'($urandom), 16'($urandom), N'($urandom), a, c, s);
        end
        ack_dly = 0; dv_dly = 0;
    endtask

    task automatic test_overrun();
        logic [22:0] a[N];
        int          outs;
        bit          addr_bad;
        int          lat;
        clear_addrs(a);
        a[0] = 23'h1234;
        ack_dly = 5; dv_dly = 0;
        checks++;
        if (Overrun !== 1'b0) begin
            errors++; $display("FAIL overrun_pre: Overrun=%b required 0", Overrun);
        end
        req_q.delete();
        SpriteInRange = 8'h01; drive_addrs(a); CurrentX = 11'sd1; CurrentY = 11'sd2; BgColour = 16'h4444;
        PixelValid = 1'b1;
        outs = 0; addr_bad = 0; lat = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge Clk); #1;
            PixelValid = (cyc == 3) ? 1'b1 : 1'b0;
            if (cyc == 3) SpriteInRange = 8'hFF;
            if (MemReq && MemAddr !== 23'h1234) addr_bad = 1;
            if (PixelOutValid) begin
                outs++;
                if (lat == 0) lat = cyc;
            end
        end
        checks++;
        if (addr_bad) begin
            errors++; $display("FAIL overrun_addr: MemAddr changed while MemReq high, required 001234");
        end
        checks++;
        if (Overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_flag: Overrun=%b required 1", Overrun);
        end
        checks++;
        if (outs != 1 || lat != 9) begin
            errors++; $display("FAIL overrun_outputs: got %0d pixels latency %0d required 1 pixel latency 9", outs, lat);
        end
        checks++;
        if (req_q.size() != 1 || PixelOut !== 16'hB7F7) begin
            errors++; $display("FAIL overrun_data: reads=%0d PixelOut=%h required 1 read b7f7", req_q.size(), PixelOut);
        end
        ack_dly = 0;
    endtask

    task automatic test_reset_mid();
        logic [22:0] a[N];
        logic [15:0] c;
        bit          s;
        int          w;
        int          outs;
        clear_addrs(a);
        a[0] = 23'h1234;
        manual = 1'b1;
        MemAck = 1'b0; MemDataValid = 1'b0;
        SpriteInRange = 8'h01; drive_addrs(a);
        PixelValid = 1'b1;
        @(posedge Clk); #1;
        PixelValid = 1'b0;
        w = 0;
        while (!MemReq && w < 20) begin
            @(posedge Clk); #1; w++;
        end
        MemAck = 1'b1;
        @(posedge Clk); #1;
        MemAck = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0;
        MemDataValid = 1'b1; MemData = 16'h0F0F;
        @(posedge Clk); #1;
        MemDataValid = 1'b0;
        outs = (PixelOutValid === 1'b1) ? 1 : 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge Clk); #1;
            if (PixelOutValid === 1'b1) outs++;
        end
        checks++;
        if (outs != 0) begin
            errors++; $display("FAIL reset_mid_output: got %0d pixels required 0", outs);
        end
        checks++;
        if (Ready !== 1'b1 || MemReq !== 1'b0 || Overrun !== 1'b0) begin
            errors++; $display("FAIL reset_mid_state: Ready=%b MemReq=%b Overrun=%b required 1 0 0", Ready, MemReq, Overrun);
        end
        manual = 1'b0;
        @(posedge Clk); #1;
        run_pixel("after_reset", 11'sd4, 11'sd4, 16'h5555, 8'h01, a, c, s);
    endtask

    initial begin
        test_reset();
        test_no_sprite();
        test_sprite_hit();
        test_zero_addr();
        test_transparent();
        test_random();
        test_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
